// File: rtl/uart_tx_pull.sv
// Pulling UART transmitter: fetches bytes from a get/data/empty source and sends 8N1 frames.
// Optional even-parity bit is enabled by defining UART_TX_PARITY_EN.
module uart_tx_pull #(
  parameter int unsigned W   = 8,
  parameter int unsigned DIV = 4
) (
  input  logic         clock,
  input  logic         reset,
  input  logic         empty,
  input  logic [W-1:0] data,
  output logic         get,
  output logic         tx,
  output logic         busy
);

  localparam int unsigned CW = (DIV > 1) ? $clog2(DIV + 1) : 1;
  localparam int unsigned BW = (W > 1) ? $clog2(W) : 1;

`ifdef UART_TX_PARITY_EN
  typedef enum logic [2:0] {
    S_IDLE, S_FETCH, S_START, S_DATA, S_PARITY, S_STOP
  } state_e;
`else
  typedef enum logic [2:0] {
    S_IDLE, S_FETCH, S_START, S_DATA, S_STOP
  } state_e;
`endif

  state_e          state_q, state_d;
  logic [W-1:0]    shift_q, shift_d;
  logic [CW-1:0]   cnt_q,   cnt_d;
  logic [BW-1:0]   bit_q,   bit_d;
  logic            tx_q,    tx_d;
  logic            baud_done;
`ifdef UART_TX_PARITY_EN
  logic            par_q,   par_d;
`endif

  assign baud_done = (cnt_q == '0);

  // State and datapath registers
  always_ff @(posedge clock) begin
    if (!reset) begin
      state_q <= S_IDLE;
      shift_q <= '0;
      cnt_q   <= '0;
      bit_q   <= '0;
      tx_q    <= 1'b1;
`ifdef UART_TX_PARITY_EN
      par_q   <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      shift_q <= shift_d;
      cnt_q   <= cnt_d;
      bit_q   <= bit_d;
      tx_q    <= tx_d;
`ifdef UART_TX_PARITY_EN
      par_q   <= par_d;
`endif
    end
  end

  // Next-state and datapath update
  always_comb begin
    state_d = state_q;
    shift_d = shift_q;
    cnt_d   = cnt_q;
    bit_d   = bit_q;
`ifdef UART_TX_PARITY_EN
    par_d   = par_q;
`endif
    unique case (state_q)
      S_IDLE: begin
        if (!empty) state_d = S_FETCH;
      end
      S_FETCH: begin
        shift_d = data;
        cnt_d   = CW'(DIV - 1);
        state_d = S_START;
`ifdef UART_TX_PARITY_EN
        par_d   = 1'b0;
`endif
      end
      S_START: begin
        if (baud_done) begin
          cnt_d   = CW'(DIV - 1);
          bit_d   = '0;
          state_d = S_DATA;
        end else begin
          cnt_d = CW'(cnt_q - 1'b1);
        end
      end
      S_DATA: begin
        if (baud_done) begin
          shift_d = shift_q >> 1;
          bit_d   = BW'(bit_q + 1'b1);
          cnt_d   = CW'(DIV - 1);
`ifdef UART_TX_PARITY_EN
          par_d   = par_q ^ shift_q[0];
          if (bit_q == BW'(W - 1)) state_d = S_PARITY;
`else
          if (bit_q == BW'(W - 1)) state_d = S_STOP;
`endif
        end else begin
          cnt_d = CW'(cnt_q - 1'b1);
        end
      end
`ifdef UART_TX_PARITY_EN
      S_PARITY: begin
        if (baud_done) begin
          cnt_d   = CW'(DIV - 1);
          state_d = S_STOP;
        end else begin
          cnt_d = CW'(cnt_q - 1'b1);
        end
      end
`endif
      S_STOP: begin
        if (baud_done) state_d = S_IDLE;
        else           cnt_d   = CW'(cnt_q - 1'b1);
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Outputs: get/busy decode the current state, tx is registered from the next state
  always_comb begin
    tx_d = 1'b1;
    get  = (state_q == S_IDLE) & ~empty & reset;
    busy = (state_q != S_IDLE) & reset;
    unique case (state_d)
      S_START:  tx_d = 1'b0;
      S_DATA:   tx_d = shift_d[0];
`ifdef UART_TX_PARITY_EN
      S_PARITY: tx_d = par_d;
`endif
      default:  tx_d = 1'b1;
    endcase
  end

  assign tx = tx_q;

endmodule
